// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 Avalon-MM read/write arbiter.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRdCmd   = 2'd1,
        StWrBurst = 2'd2
    } arb_state_e;

    localparam int unsigned BurstLenDefault = 4;
    localparam int unsigned RdRunW          = 4;
    localparam int unsigned BeatW           = 3;

endpackage

// File: rtl/ddr3_avl_arbiter.sv
// Shares one DDR3 Avalon-MM port between the display reader and the capture writer.
// Reads have priority, but a writer that has waited through MAX_RD_RUN reads gets one whole burst.
module ddr3_avl_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 26,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned BURST_LEN  = BurstLenDefault,
    parameter int unsigned MAX_RD_RUN = 8
) (
    input  logic                ddr3_clk,
    input  logic                reset_n,

    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_ready,
    output logic                rd_rdata_valid,
    output logic [DATA_W-1:0]   rd_rdata,

    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_wdata,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                wr_ready,

    input  logic                avl_ready,
    output logic                avl_burstbegin,
    output logic                avl_read_req,
    output logic                avl_write_req,
    output logic [ADDR_W-1:0]   avl_addr,
    output logic [2:0]          avl_size,
    output logic [DATA_W-1:0]   avl_wdata,
    output logic [DATA_W/8-1:0] avl_be,
    input  logic                avl_rdata_valid,
    input  logic [DATA_W-1:0]   avl_rdata,

    output logic                grant_wr
);

    if (BURST_LEN < 1 || BURST_LEN > 7) begin : g_bad_burst_len
        $error("BURST_LEN must be in 1..7");
    end
    if (MAX_RD_RUN < 1 || MAX_RD_RUN > 15) begin : g_bad_max_rd_run
        $error("MAX_RD_RUN must be in 1..15");
    end

    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

    arb_state_e        state_q, state_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [RdRunW-1:0] rd_run_q, rd_run_d;
    logic              starve;

    // Writer has watched MAX_RD_RUN reads go by and is still waiting.
    assign starve = wr_req && (32'(rd_run_q) == MAX_RD_RUN);

    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            rd_run_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rd_run_q <= rd_run_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        rd_run_d       = rd_run_q;
        rd_ready       = 1'b0;
        wr_ready       = 1'b0;
        avl_burstbegin = 1'b0;
        avl_read_req   = 1'b0;
        avl_write_req  = 1'b0;
        avl_addr       = '0;
        avl_wdata      = '0;
        avl_be         = '0;

        unique case (state_q)
            StIdle: begin
                if (!wr_req) begin
                    rd_run_d = '0;
                end
                if (rd_req && !starve) begin
                    state_d = StRdCmd;
                end else if (wr_req) begin
                    state_d = StWrBurst;
                end
            end

            StRdCmd: begin
                avl_read_req   = rd_req;
                avl_burstbegin = rd_req;
                avl_addr       = rd_addr;
                if (avl_ready && rd_req) begin
                    rd_ready = 1'b1;
                    state_d  = StIdle;
                    if (wr_req && (rd_run_q != '1)) begin
                        rd_run_d = rd_run_q + RdRunW'(1);
                    end
                end
            end

            StWrBurst: begin
                // Grant is held through writer gaps so the burst is never split.
                avl_write_req  = wr_req;
                avl_burstbegin = wr_req && (beat_q == '0);
                avl_addr       = wr_addr;
                avl_wdata      = wr_wdata;
                avl_be         = wr_be;
                if (avl_ready && wr_req) begin
                    wr_ready = 1'b1;
                    if (beat_q == LastBeat) begin
                        beat_d   = '0;
                        rd_run_d = '0;
                        state_d  = StIdle;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign grant_wr       = (state_q == StWrBurst);
    assign avl_size       = 3'(BURST_LEN);
    assign rd_rdata_valid = avl_rdata_valid;
    assign rd_rdata       = avl_rdata;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Self-checking bench for ddr3_avl_arbiter: directed scenarios plus randomized traffic,
// with every cycle compared against a transaction-level model of the arbitration rules.
module tb_ddr3_avl_arbiter;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BL     = 4;
    localparam int unsigned MAXR   = 8;

    logic                ddr3_clk = 1'b0;
    logic                reset_n  = 1'b0;
    logic                rd_req, rd_ready, rd_rdata_valid;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_rdata;
    logic                wr_req, wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_wdata;
    logic [DATA_W/8-1:0] wr_be;
    logic                avl_ready, avl_burstbegin, avl_read_req, avl_write_req;
    logic [ADDR_W-1:0]   avl_addr;
    logic [2:0]          avl_size;
    logic [DATA_W-1:0]   avl_wdata;
    logic [DATA_W/8-1:0] avl_be;
    logic                avl_rdata_valid;
    logic [DATA_W-1:0]   avl_rdata;
    logic                grant_wr;

    always #5 ddr3_clk = ~ddr3_clk;

    ddr3_avl_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BURST_LEN  (BL),
        .MAX_RD_RUN (MAXR)
    ) dut (
        .ddr3_clk        (ddr3_clk),
        .reset_n         (reset_n),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_ready        (rd_ready),
        .rd_rdata_valid  (rd_rdata_valid),
        .rd_rdata        (rd_rdata),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_wdata        (wr_wdata),
        .wr_be           (wr_be),
        .wr_ready        (wr_ready),
        .avl_ready       (avl_ready),
        .avl_burstbegin  (avl_burstbegin),
        .avl_read_req    (avl_read_req),
        .avl_write_req   (avl_write_req),
        .avl_addr        (avl_addr),
        .avl_size        (avl_size),
        .avl_wdata       (avl_wdata),
        .avl_be          (avl_be),
        .avl_rdata_valid (avl_rdata_valid),
        .avl_rdata       (avl_rdata),
        .grant_wr        (grant_wr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: cycle budget expired before completion", name);
    endtask

    function automatic logic [63:0] dat(input int b);
        return 64'hD0D0_0000_0000_0000 + 64'(b);
    endfunction

    // Transaction-level model: who owns the port, beats written, reads served since last write.
    localparam int OwnNone = 0, OwnRd = 1, OwnWr = 2;
    int m_owner = OwnNone;
    int m_beats = 0;
    int m_reads = 0;

    logic        e_rd_ready, e_wr_ready, e_rq, e_wq, e_bb, e_gw;
    logic [63:0] e_addr, e_wd, e_be;

    always @(negedge ddr3_clk) begin
        if (!reset_n) begin
            m_owner = OwnNone;
            m_beats = 0;
            m_reads = 0;
        end
        e_rd_ready = 0; e_wr_ready = 0; e_rq = 0; e_wq = 0; e_bb = 0;
        e_addr = 0; e_wd = 0; e_be = 0;
        e_gw = (m_owner == OwnWr);
        if (m_owner == OwnRd) begin
            e_rq       = rd_req;
            e_bb       = rd_req;
            e_addr     = 64'(rd_addr);
            e_rd_ready = rd_req & avl_ready;
        end else if (m_owner == OwnWr) begin
            e_wq       = wr_req;
            e_bb       = wr_req && (m_beats == 0);
            e_addr     = 64'(wr_addr);
            e_wd       = wr_wdata;
            e_be       = 64'(wr_be);
            e_wr_ready = wr_req & avl_ready;
        end
        chk("rd_ready", rd_ready, e_rd_ready);
        chk("wr_ready", wr_ready, e_wr_ready);
        chk("avl_read_req", avl_read_req, e_rq);
        chk("avl_write_req", avl_write_req, e_wq);
        chk("avl_burstbegin", avl_burstbegin, e_bb);
        chk("avl_addr", avl_addr, e_addr);
        chk("avl_wdata", avl_wdata, e_wd);
        chk("avl_be", avl_be, e_be);
        chk("grant_wr", grant_wr, e_gw);
        chk("avl_size", avl_size, 64'(BL));
        chk("rd_rdata_valid", rd_rdata_valid, avl_rdata_valid);
        chk("rd_rdata", rd_rdata, avl_rdata);

        if (reset_n) begin
            if (m_owner == OwnNone) begin
                if (!wr_req) m_reads = 0;
                if (rd_req && !(wr_req && m_reads == MAXR)) m_owner = OwnRd;
                else if (wr_req) m_owner = OwnWr;
            end else if (m_owner == OwnRd) begin
                if (rd_req && avl_ready) begin
                    m_owner = OwnNone;
                    if (wr_req && m_reads < 15) m_reads++;
                end
            end else begin
                if (wr_req && avl_ready) begin
                    m_beats++;
                    if (m_beats == BL) begin
                        m_beats = 0;
                        m_reads = 0;
                        m_owner = OwnNone;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ddr3_clk);
        #1;
    endtask

    task automatic quiet();
        rd_req = 0; wr_req = 0; avl_ready = 1; avl_rdata_valid = 0;
        wr_be = '1;
    endtask

    // One write burst with optional avl_ready stall at a beat, writer gap after a beat,
    // and a read request raised once the writer owns the port.
    task automatic run_burst(input string tag, input int stall_beat, input int stall_len,
                             input int gap_after, input int gap_len, input logic rd_on);
        int acc_n = 0, stall = 0, gap = 0, nbb = 0, rd_seen = 0;
        logic acc;
        quiet();
        tick();
        wr_req = 1; wr_addr = 26'h0AB_CDE0; wr_wdata = dat(0);
        @(negedge ddr3_clk);
        tick();
        if (rd_on) begin
            rd_req = 1; rd_addr = 26'h0000_77;
        end
        for (int c = 0; c < 40 && acc_n < int'(BL); c++) begin
            avl_ready = !(acc_n == stall_beat && stall < stall_len);
            @(negedge ddr3_clk);
            if (avl_read_req) rd_seen++;
            if (avl_burstbegin) nbb++;
            if (!wr_req) begin
                chk({tag, "_gap_wq"}, avl_write_req, 0);
                chk({tag, "_gap_grant"}, grant_wr, 1);
            end
            if (!avl_ready) chk({tag, "_stall_data"}, avl_wdata, dat(acc_n));
            acc = wr_ready;
            tick();
            if (!avl_ready) stall++;
            if (acc) begin
                acc_n++;
                if (acc_n == int'(BL)) begin
                    wr_req = 0;
                end else if (acc_n == gap_after + 1 && gap_len > 0) begin
                    wr_req = 0;
                    gap = gap_len;
                end else begin
                    wr_wdata = dat(acc_n);
                end
            end else if (gap > 0) begin
                gap--;
                if (gap == 0) begin
                    wr_req = 1;
                    wr_wdata = dat(acc_n);
                end
            end
        end
        avl_ready = 1;
        if (acc_n < int'(BL)) timeout({tag, "_burst"});
        chk({tag, "_beats"}, 64'(acc_n), 64'(BL));
        chk({tag, "_burstbegins"}, 64'(nbb), 1);
        chk({tag, "_reads_during_burst"}, 64'(rd_seen), 0);
        if (rd_on) begin
            @(negedge ddr3_clk);
            tick();
            @(negedge ddr3_clk);
            chk({tag, "_read_after_burst"}, avl_read_req, 1);
            tick();
            rd_req = 0;
        end
        quiet();
    endtask

    initial begin
        int nrd, nwr, first, after;
        logic rd_acc, wr_acc;
        int in_burst, wbeat;

        quiet();
        rd_req = 1; wr_req = 1; rd_addr = 26'h123; wr_addr = 26'h456; wr_wdata = dat(9);
        avl_rdata = '0;
        repeat (2) tick();
        @(negedge ddr3_clk);
        chk("rst_grant", grant_wr, 0);
        chk("rst_read_req", avl_read_req, 0);
        chk("rst_write_req", avl_write_req, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_size", avl_size, 4);
        tick();
        quiet();
        reset_n = 1;
        tick();

        // Read only: command at N+1, bubble at N+2, next command at N+3.
        rd_req = 1; rd_addr = 26'h100;
        @(negedge ddr3_clk);
        chk("rd_idle_n", avl_read_req, 0);
        tick();
        @(negedge ddr3_clk);
        chk("rd_cmd", avl_read_req, 1);
        chk("rd_bb", avl_burstbegin, 1);
        chk("rd_addr", avl_addr, 26'h100);
        chk("rd_ready_n1", rd_ready, 1);
        tick();
        rd_addr = 26'h140;
        @(negedge ddr3_clk);
        chk("rd_bubble", avl_read_req, 0);
        chk("rd_ready_bubble", rd_ready, 0);
        tick();
        @(negedge ddr3_clk);
        chk("rd_next_n3", avl_read_req, 1);
        chk("rd_next_addr", avl_addr, 26'h140);
        tick();
        quiet();
        tick();

        // Write only: four beats at 0x200, burstbegin on beat 0 only.
        wr_req = 1; wr_addr = 26'h200; wr_wdata = dat(0);
        @(negedge ddr3_clk);
        chk("wr_grant_idle", grant_wr, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            @(negedge ddr3_clk);
            chk("wr_bb", avl_burstbegin, (b == 0));
            chk("wr_addr", avl_addr, 26'h200);
            chk("wr_data", avl_wdata, dat(b));
            chk("wr_ready", wr_ready, 1);
            chk("wr_grant", grant_wr, 1);
            tick();
            if (b < 3) wr_wdata = dat(b + 1);
            else wr_req = 0;
        end
        @(negedge ddr3_clk);
        chk("wr_grant_drop", grant_wr, 0);
        tick();

        // Both requesting continuously: 8 reads, one 4-beat write, then reads resume.
        rd_req = 1; rd_addr = 26'h1000; wr_req = 1; wr_addr = 26'h300; wr_wdata = dat(0);
        nrd = 0; nwr = 0; first = 0;
        for (int c = 0; c < 80 && nwr < 4; c++) begin
            @(negedge ddr3_clk);
            if (first == 0 && (avl_read_req || avl_write_req)) first = avl_read_req ? 1 : 2;
            if (rd_ready && nwr == 0) nrd++;
            rd_acc = rd_ready;
            wr_acc = wr_ready;
            tick();
            if (rd_acc) rd_addr = rd_addr + 26'h40;
            if (wr_acc) begin
                nwr++;
                if (nwr == 4) wr_req = 0;
                else wr_wdata = dat(nwr);
            end
        end
        if (nwr < 4) timeout("starve_write");
        chk("starve_first_is_read", 64'(first), 1);
        chk("starve_reads_before_write", 64'(nrd), 8);
        after = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge ddr3_clk);
            if (rd_ready) after++;
            tick();
        end
        chk("starve_reads_resume", 64'(after), 2);
        quiet();
        tick();

        run_burst("stall", 2, 3, -1, 0, 1'b1);
        run_burst("gap", -1, 0, 1, 2, 1'b0);

        // Reset during write beat 2, then a fresh burst must start with burstbegin.
        tick();
        wr_req = 1; wr_addr = 26'h400; wr_wdata = dat(0);
        @(negedge ddr3_clk);
        tick();
        for (int b = 0; b < 2; b++) begin
            @(negedge ddr3_clk);
            tick();
            wr_wdata = dat(b + 1);
        end
        #2 reset_n = 0;
        #1;
        chk("rst_mid_write_req", avl_write_req, 0);
        chk("rst_mid_grant", grant_wr, 0);
        chk("rst_mid_wr_ready", wr_ready, 0);
        chk("rst_mid_bb", avl_burstbegin, 0);
        wr_req = 0;
        tick();
        tick();
        reset_n = 1;
        wr_req = 1; wr_addr = 26'h500; wr_wdata = dat(0);
        @(negedge ddr3_clk);
        chk("post_rst_idle", grant_wr, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            @(negedge ddr3_clk);
            chk("post_rst_bb", avl_burstbegin, (b == 0));
            chk("post_rst_ready", wr_ready, 1);
            tick();
            if (b < 3) wr_wdata = dat(b + 1);
            else wr_req = 0;
        end
        quiet();
        tick();

        // Randomized traffic, both masters obeying hold-until-ready.
        in_burst = 0;
        wbeat = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge ddr3_clk);
            rd_acc = rd_ready;
            wr_acc = wr_ready;
            tick();
            if (rd_req && rd_acc) rd_req = 0;
            if (!rd_req && $urandom_range(0, 2) != 0) begin
                rd_req = 1;
                rd_addr = ADDR_W'($urandom);
            end
            if (wr_req && wr_acc) begin
                wr_req = 0;
                wbeat++;
                if (wbeat == int'(BL)) begin
                    in_burst = 0;
                    wbeat = 0;
                end
            end
            if (!wr_req) begin
                if (in_burst != 0) begin
                    if ($urandom_range(0, 3) != 0) begin
                        wr_req = 1;
                        wr_wdata = {$urandom, $urandom};
                        wr_be = 8'($urandom);
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    in_burst = 1;
                    wr_addr = ADDR_W'($urandom);
                    wr_req = 1;
                    wr_wdata = {$urandom, $urandom};
                    wr_be = 8'($urandom);
                end
            end
            avl_ready = ($urandom_range(0, 3) != 0);
            avl_rdata_valid = 1'($urandom_range(0, 1));
            avl_rdata = {$urandom, $urandom};
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
